// File: rtl/sum_select_pkg.sv
// sum_select_pkg: shared types and the result-resolve helper for sum_select_unit.
//   WIDTH        - operand/result width; bit 0 is MSB ([0:WIDTH-1]), matching the adder slice.
//   res_t        - resolved result {mag, sign, zero, ovf}.
//   skid_state_t - occupancy of the 2-entry output skid buffer.
//   resolve()    - turns the adder's dual outputs into magnitude/sign or sum/overflow.
package sum_select_pkg;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [0:WIDTH-1] mag;
        logic             sign;
        logic             zero;
        logic             ovf;
    } res_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } skid_state_t;

    // In subtract mode a missing carry-out means A < B, so the magnitude is taken
    // from the inverted-sum path. Zero is never reported as negative.
    function automatic res_t resolve(input logic             sub,
                                     input logic [0:WIDTH-1] s,
                                     input logic [0:WIDTH-1] s_invert,
                                     input logic             c_out1);
        res_t r;
        r.mag  = s;
        r.sign = 1'b0;
        r.ovf  = 1'b0;
        if (!sub) begin
            r.ovf = c_out1;
        end else if (!c_out1) begin
            r.mag  = s_invert;
            r.sign = 1'b1;
        end
        r.zero = (r.mag == '0);
        if (r.zero) begin
            r.sign = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sum_select_unit_if.sv
// sum_select_unit_if: input handshake, adder-slice data, output result bus and status.
//   slave  - the unit's view (takes adder results, drives result bus and status).
//   master - the environment's view (drives adder results, consumes result bus).
interface sum_select_unit_if #(
    parameter int unsigned width     = sum_select_pkg::WIDTH,
    parameter int unsigned cnt_width = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 sub;
    logic [0:width-1]     s;
    logic [0:width-1]     s_invert;
    logic                 c_out1;
    logic                 c_out2;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:width-1]     mag;
    logic                 sign;
    logic                 zero;
    logic                 ovf;
    logic                 ovf_sticky;
    logic                 clr;
    logic [cnt_width-1:0] txn_cnt;

    modport slave (
        input  in_valid, sub, s, s_invert, c_out1, c_out2, out_ready, clr,
        output in_ready, out_valid, mag, sign, zero, ovf, ovf_sticky, txn_cnt
    );

    modport master (
        output in_valid, sub, s, s_invert, c_out1, c_out2, out_ready, clr,
        input  in_ready, out_valid, mag, sign, zero, ovf, ovf_sticky, txn_cnt
    );
endinterface

// File: rtl/sum_skid_buffer.sv
// sum_skid_buffer: generic 2-entry valid/ready buffer, strict FIFO order.
//   clk, rst_n              - clock, asynchronous active-low reset.
//   i_in_valid/o_in_ready   - upstream handshake; o_in_ready is a flop, low only when full.
//   i_in_data               - upstream payload.
//   o_out_valid/i_out_ready - downstream handshake; o_out_valid is a flop.
//   o_out_data              - head entry; held stable while stalled, cleared only by reset.
module sum_skid_buffer
    import sum_select_pkg::*;
#(
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [DataWidth-1:0] i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [DataWidth-1:0] o_out_data
);

    skid_state_t          r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [DataWidth-1:0] r_head;
    logic [DataWidth-1:0] r_skid;
    logic                 w_acc;
    logic                 w_xfer;

    assign w_acc  = i_in_valid & r_in_ready;
    assign w_xfer = r_out_valid & i_out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head      <= '0;
            r_skid      <= '0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        r_head      <= i_in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ONE;
                    end
                end
                ONE: begin
                    if (w_acc && !w_xfer) begin
                        r_skid     <= i_in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= TWO;
                    end else if (w_acc && w_xfer) begin
                        r_head <= i_in_data;
                    end else if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (w_xfer) begin
                        r_head     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ONE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= EMPTY;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_head;

endmodule

// File: rtl/sum_select_unit.sv
// sum_select_unit: registered consumer of the dual-output carry-select adder slice.
//   clk, rst_n - clock, asynchronous active-low reset.
//   bus        - slave side of sum_select_unit_if: adder results in (in_valid/in_ready,
//                sub, s, s_invert, c_out1, c_out2), resolved result out (out_valid/out_ready,
//                mag, sign, zero, ovf), status (ovf_sticky, txn_cnt) and synchronous clr.
// width must equal sum_select_pkg::WIDTH since res_t is sized by the package.
module sum_select_unit
    import sum_select_pkg::*;
#(
    parameter int unsigned width     = WIDTH,
    parameter int unsigned cnt_width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sum_select_unit_if.slave bus
);

    logic [0:width-1]     w_s;
    logic [0:width-1]     w_s_invert;
    res_t                 w_res;
    res_t                 w_head;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_xfer;
    logic                 r_ovf_sticky;
    logic [cnt_width-1:0] r_txn_cnt;

    assign w_s        = bus.s;
    assign w_s_invert = bus.s_invert;
    assign w_res      = resolve(bus.sub, w_s, w_s_invert, bus.c_out1);
    assign w_xfer     = w_out_valid & bus.out_ready;

    sum_skid_buffer #(
        .DataWidth($bits(res_t))
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (bus.in_valid),
        .o_in_ready (w_in_ready),
        .i_in_data  (w_res),
        .o_out_valid(w_out_valid),
        .i_out_ready(bus.out_ready),
        .o_out_data (w_head)
    );

    // clr has priority: a result transferred in the clearing cycle is neither
    // counted nor recorded in the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_txn_cnt    <= '0;
        end else if (bus.clr) begin
            r_ovf_sticky <= 1'b0;
            r_txn_cnt    <= '0;
        end else if (w_xfer) begin
            r_txn_cnt <= r_txn_cnt + cnt_width'(1);
            if (w_head.ovf) begin
                r_ovf_sticky <= 1'b1;
            end
        end
    end

    // A subtract result must come with exactly one of the two carry-outs set.
    always_ff @(posedge clk) begin
        if (rst_n && bus.in_valid && w_in_ready && bus.sub) begin
            assert (bus.c_out1 ^ bus.c_out2);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.mag        = w_head.mag;
    assign bus.sign       = w_head.sign;
    assign bus.zero       = w_head.zero;
    assign bus.ovf        = w_head.ovf;
    assign bus.ovf_sticky = r_ovf_sticky;
    assign bus.txn_cnt    = r_txn_cnt;

endmodule

// File: tb/tb_sum_select_unit.sv
module tb_sum_select_unit;

    typedef struct {
        logic [7:0] mag;
        logic       sign;
        logic       zero;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   sb_en    = 1'b1;
    exp_t sb_q[$];

    sum_select_unit_if #(.width(8), .cnt_width(16)) bus ();

    sum_select_unit #(.width(8), .cnt_width(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Transfer happens on the next rising edge; compare against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && sb_en && bus.out_valid && bus.out_ready) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_mag", bus.mag, e.mag);
                chk("sb_sign", bus.sign, e.sign);
                chk("sb_zero", bus.zero, e.zero);
                chk("sb_ovf", bus.ovf, e.ovf);
            end
        end
    end

    // Call only just after a rising edge.
    task automatic drive(input logic sb, input logic [7:0] s, input logic [7:0] si,
                         input logic c1, input logic c2, input logic [7:0] em,
                         input logic es, input logic ez, input logic eo);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.sub      = sb;
        bus.s        = s;
        bus.s_invert = si;
        bus.c_out1   = c1;
        bus.c_out2   = c2;
        e.mag  = em;
        e.sign = es;
        e.zero = ez;
        e.ovf  = eo;
        sb_q.push_back(e);
    endtask

    task automatic wait_accept();
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic sb, input logic [7:0] s, input logic [7:0] si,
                        input logic c1, input logic c2, input logic [7:0] em,
                        input logic es, input logic ez, input logic eo);
        drive(sb, s, si, c1, c2, em, es, ez, eo);
        wait_accept();
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, sb_q.size(), 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_x;
        int guard;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sub       = 1'b0;
        bus.s         = 8'h00;
        bus.s_invert  = 8'h00;
        bus.c_out1    = 1'b0;
        bus.c_out2    = 1'b0;
        bus.out_ready = 1'b0;
        bus.clr       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_mag", bus.mag, 0);
        chk("rst_sign", bus.sign, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_sticky", bus.ovf_sticky, 0);
        chk("rst_cnt", bus.txn_cnt, 0);
        rst_n = 1'b1;
        cyc();

        // Add with carry-out: one-cycle latency, then sticky and count after transfer.
        bus.out_ready = 1'b1;
        send(0, 8'h10, 8'hEF, 1, 0, 8'h10, 0, 0, 1);
        chk("add_latency_valid", bus.out_valid, 1);
        chk("add_latency_mag", bus.mag, 8'h10);
        cyc();
        chk("add_sticky", bus.ovf_sticky, 1);
        chk("add_cnt", bus.txn_cnt, 1);

        // Streamed: subtract positive, subtract negative, subtract zero, add zero with carry.
        send(1, 8'h23, 8'hDC, 1, 0, 8'h23, 0, 0, 0);
        send(1, 8'hDD, 8'h23, 0, 1, 8'h23, 1, 0, 0);
        send(1, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 1, 0);
        send(0, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 1, 1);
        drain("stream_drain");
        chk("stream_cnt", bus.txn_cnt, 5);

        // Plain clear.
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        chk("clr_sticky", bus.ovf_sticky, 0);
        chk("clr_cnt", bus.txn_cnt, 0);

        // Back-pressure: third result held upstream until the buffer drains.
        bus.out_ready = 1'b0;
        send(0, 8'h01, 8'hFE, 0, 0, 8'h01, 0, 0, 0);
        chk("bp_ready_after1", bus.in_ready, 1);
        send(0, 8'h02, 8'hFD, 0, 0, 8'h02, 0, 0, 0);
        chk("bp_ready_after2", bus.in_ready, 0);
        drive(0, 8'h03, 8'hFC, 1, 0, 8'h03, 0, 0, 1);
        repeat (3) begin
            cyc();
            chk("bp_hold_ready", bus.in_ready, 0);
            chk("bp_hold_mag", bus.mag, 8'h01);
            chk("bp_hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        wait_accept();
        drain("bp_drain");
        chk("bp_cnt", bus.txn_cnt, 3);
        chk("bp_sticky", bus.ovf_sticky, 1);

        // Asynchronous reset with the buffer full.
        bus.out_ready = 1'b0;
        send(0, 8'h11, 8'hEE, 0, 0, 8'h11, 0, 0, 0);
        send(0, 8'h12, 8'hED, 0, 0, 8'h12, 0, 0, 0);
        chk("two_full", bus.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_mag", bus.mag, 0);
        chk("arst_sign", bus.sign, 0);
        chk("arst_zero", bus.zero, 0);
        chk("arst_ovf", bus.ovf, 0);
        chk("arst_sticky", bus.ovf_sticky, 0);
        chk("arst_cnt", bus.txn_cnt, 0);
        sb_q.delete();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_valid", bus.out_valid, 0);

        // Clear coinciding with a transfer of an overflowing result.
        bus.out_ready = 1'b1;
        send(0, 8'h40, 8'hBF, 0, 0, 8'h40, 0, 0, 0);
        drain("pre_clr_drain");
        chk("pre_clr_cnt", bus.txn_cnt, 1);
        send(0, 8'h80, 8'h7F, 1, 0, 8'h80, 0, 0, 1);
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
        chk("clr_xfer_cnt", bus.txn_cnt, 0);
        chk("clr_xfer_sticky", bus.ovf_sticky, 0);
        chk("clr_xfer_sb", sb_q.size(), 0);

        // Counter wrap: 65535 transfers, then one more.
        sb_en        = 1'b0;
        bus.in_valid = 1'b1;
        bus.sub      = 1'b0;
        bus.s        = 8'h55;
        bus.s_invert = 8'hAA;
        bus.c_out1   = 1'b0;
        bus.c_out2   = 1'b0;
        n_x   = 0;
        guard = 0;
        while (n_x < 65535 && guard < 70000) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) n_x++;
            guard++;
        end
        chk("wrap_xfers", n_x, 65535);
        cyc();
        bus.in_valid = 1'b0;
        chk("wrap_ffff", bus.txn_cnt, 16'hFFFF);
        cyc();
        chk("wrap_zero", bus.txn_cnt, 16'h0000);
        chk("wrap_empty", bus.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
